calc_datapath: RTL and testbench

//   Datapath of the small calculator. Sits directly downstream of control_unit and consumes its
//   s1/WA/WE/RAA/REA/RAB/REB/C/s2 word each cycle.

---
 rtl/calc_datapath.sv | 117 +++++++++++
 tb/tb_calc_datapath.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_datapath.sv
//==============================================================================
// Module      : calc_datapath
// Description : Calculator datapath. Holds a 4-entry register file, an operand
//               latch pair, a 4-function ALU, a write-back mux and a registered
//               result stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module calc_datapath #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       s1,
    input  logic [1:0]       WA,
    input  logic             WE,
    input  logic [1:0]       RAA,
    input  logic             REA,
    input  logic [1:0]       RAB,
    input  logic             REB,
    input  logic [1:0]       C,
    input  logic             s2,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             valid
);

    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_sub = 2'b01;
    localparam logic [1:0] c_op_and = 2'b10;

    logic [WIDTH-1:0] r_rf [4];
    logic [WIDTH-1:0] r_qa;
    logic [WIDTH-1:0] r_qb;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;
    logic             r_valid;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_alu;
    logic             w_cy;
    logic [WIDTH-1:0] w_mux1;

    // The extra top bit of the difference is the borrow, i.e. qa < qb.
    assign w_sum  = {1'b0, r_qa} + {1'b0, r_qb};
    assign w_diff = {1'b0, r_qa} - {1'b0, r_qb};

    always_comb begin
        w_alu = r_qa ^ r_qb;
        w_cy  = 1'b0;
        case (C)
            c_op_add: begin
                w_alu = w_sum[WIDTH-1:0];
                w_cy  = w_sum[WIDTH];
            end
            c_op_sub: begin
                w_alu = w_diff[WIDTH-1:0];
                w_cy  = w_diff[WIDTH];
            end
            c_op_and: w_alu = r_qa & r_qb;
            default:  w_alu = r_qa ^ r_qb;
        endcase
    end

    always_comb begin
        case (s1)
            2'b11:   w_mux1 = in1;
            2'b10:   w_mux1 = in2;
            2'b01:   w_mux1 = '0;
            default: w_mux1 = w_alu;
        endcase
    end

    // Reads sample the pre-edge register file; no write-through bypass.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= '0;
            end
            r_qa    <= '0;
            r_qb    <= '0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (REA) begin
                r_qa <= r_rf[RAA];
            end
            if (REB) begin
                r_qb <= r_rf[RAB];
            end
            if (WE) begin
                r_rf[WA] <= w_mux1;
                if (s1 == 2'b00) begin
                    r_ovf <= w_cy;
                end
            end
            if (s2) begin
                r_out   <= r_rf[3];
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out   = r_out;
    assign ovf   = r_ovf;
    assign valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_calc_datapath.sv
//==============================================================================
// Module      : tb_calc_datapath
// Description : Self-checking bench for calc_datapath against a behavioural
//               model of the calculator datapath.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_calc_datapath;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in1 = '0;
    logic [3:0] in2 = '0;
    logic [1:0] s1  = '0;
    logic [1:0] wa  = '0;
    logic       we  = 1'b0;
    logic [1:0] raa = '0;
    logic       rea = 1'b0;
    logic [1:0] rab = '0;
    logic       reb = 1'b0;
    logic [1:0] c   = '0;
    logic       s2  = 1'b0;
    logic [3:0] out;
    logic       ovf;
    logic       valid;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [3:0] m_rf [4];
    logic [3:0] m_qa  = '0;
    logic [3:0] m_qb  = '0;
    logic [3:0] m_out = '0;
    logic       m_ovf = 1'b0;
    logic       m_valid = 1'b0;

    calc_datapath #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .in1   (in1),
        .in2   (in2),
        .s1    (s1),
        .WA    (wa),
        .WE    (we),
        .RAA   (raa),
        .REA   (rea),
        .RAB   (rab),
        .REB   (reb),
        .C     (c),
        .s2    (s2),
        .out   (out),
        .ovf   (ovf),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b1;
        s1  = '0; wa = '0; we = 1'b0;
        raa = '0; rea = 1'b0; rab = '0; reb = 1'b0;
        c   = '0; s2 = 1'b0;
    endtask

    // One clock: advance the model from the applied controls, then compare.
    task automatic tick();
        int a, b, res;
        bit cy;
        logic [3:0] m, rd_a, rd_b;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_rf[i] = '0;
            m_qa = '0; m_qb = '0; m_out = '0; m_ovf = 1'b0; m_valid = 1'b0;
        end else begin
            a = int'(m_qa);
            b = int'(m_qb);
            cy = 1'b0;
            case (c)
                2'b00:   begin res = a + b; cy = (res >= 16); res = res % 16; end
                2'b01:   begin cy = (a < b); res = (a - b + 16) % 16; end
                2'b10:   res = a & b;
                default: res = a ^ b;
            endcase
            case (s1)
                2'b11:   m = in1;
                2'b10:   m = in2;
                2'b01:   m = 4'd0;
                default: m = 4'(res);
            endcase
            rd_a = m_rf[raa];
            rd_b = m_rf[rab];
            if (s2) m_out = m_rf[3];
            m_valid = s2;
            if (rea) m_qa = rd_a;
            if (reb) m_qb = rd_b;
            if (we) begin
                m_rf[wa] = m;
                if (s1 == 2'b00) m_ovf = cy;
            end
        end
        #1;
        check("model_out", out, m_out);
        check("model_ovf", {3'b000, ovf}, {3'b000, m_ovf});
        check("model_valid", {3'b000, valid}, {3'b000, m_valid});
    endtask

    task automatic random_controls();
        in1 = 4'($urandom); in2 = 4'($urandom);
        s1  = 2'($urandom); wa  = 2'($urandom); we  = 1'($urandom);
        raa = 2'($urandom); rea = 1'($urandom);
        rab = 2'($urandom); reb = 1'($urandom);
        c   = 2'($urandom); s2  = 1'($urandom);
    endtask

    // Route RF[k] to out: qa=qb=RF[k], R3 = qa & qb, then load out.
    task automatic read_reg(input logic [1:0] k);
        idle(); raa = k; rea = 1'b1; rab = k; reb = 1'b1; tick();
        idle(); s1 = 2'b00; wa = 2'd3; we = 1'b1; c = 2'b10; tick();
        idle(); s2 = 1'b1; tick();
        idle();
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          input logic [3:0] exp_out, input logic exp_ovf, input string tag);
        idle(); in1 = a; s1 = 2'b11; wa = 2'd1; we = 1'b1; tick();
        idle(); in2 = b; s1 = 2'b10; wa = 2'd2; we = 1'b1; tick();
        idle(); raa = 2'd1; rea = 1'b1; rab = 2'd2; reb = 1'b1; tick();
        idle(); s1 = 2'b00; wa = 2'd3; we = 1'b1; c = op; repeat (4) tick();
        idle(); s2 = 1'b1; tick();
        check({tag, "_out"}, out, exp_out);
        check({tag, "_ovf"}, {3'b000, ovf}, {3'b000, exp_ovf});
        check({tag, "_valid_hi"}, {3'b000, valid}, 4'd1);
        idle(); tick();
        check({tag, "_valid_lo"}, {3'b000, valid}, 4'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_rf[i] = '0;

        // Reset with random controls applied
        rst = 1'b0; random_controls(); tick();
        rst = 1'b0; random_controls(); tick();
        check("rst_out", out, 4'd0);
        check("rst_ovf", {3'b000, ovf}, 4'd0);
        check("rst_valid", {3'b000, valid}, 4'd0);
        for (int k = 0; k < 4; k++) begin
            read_reg(2'(k));
            check("rst_rf", out, 4'd0);
        end

        run_op(4'd9, 4'd8, 2'b00, 4'd1, 1'b1, "add");
        run_op(4'd3, 4'd5, 2'b01, 4'hE, 1'b1, "sub_borrow");
        run_op(4'd5, 4'd3, 2'b01, 4'd2, 1'b0, "sub_noborrow");
        run_op(4'b1100, 4'b1010, 2'b10, 4'b1000, 1'b0, "and");
        run_op(4'b1100, 4'b1010, 2'b11, 4'b0110, 1'b0, "xor");

        // Read/write on the same address in the same edge returns the old value
        idle(); in1 = 4'd2; s1 = 2'b11; wa = 2'd1; we = 1'b1; tick();
        idle(); in1 = 4'd7; s1 = 2'b11; wa = 2'd1; we = 1'b1;
        raa = 2'd1; rea = 1'b1; rab = 2'd1; reb = 1'b1; tick();
        idle(); s1 = 2'b00; wa = 2'd3; we = 1'b1; c = 2'b10; tick();
        idle(); s2 = 1'b1; tick();
        check("hazard_old", out, 4'd2);
        read_reg(2'd1);
        check("hazard_new", out, 4'd7);

        // R3 write coinciding with s2 exposes the old R3
        idle(); s1 = 2'b01; wa = 2'd3; we = 1'b1; s2 = 1'b1; tick();
        check("wr_s2_old", out, 4'd7);
        idle(); s2 = 1'b1; tick();
        check("zero_write", out, 4'd0);

        // Reset in the middle of an add
        idle(); in1 = 4'd9; s1 = 2'b11; wa = 2'd1; we = 1'b1; tick();
        idle(); in2 = 4'd4; s1 = 2'b10; wa = 2'd2; we = 1'b1; tick();
        idle(); raa = 2'd1; rea = 1'b1; rab = 2'd2; reb = 1'b1; tick();
        idle(); s2 = 1'b1; tick();
        idle(); s1 = 2'b00; wa = 2'd3; we = 1'b1; c = 2'b00; tick();
        idle(); s1 = 2'b00; wa = 2'd3; we = 1'b1; c = 2'b00; rst = 1'b0; tick();
        check("midrst_out", out, 4'd0);
        check("midrst_valid", {3'b000, valid}, 4'd0);
        idle(); s2 = 1'b1; tick();
        check("midrst_s8_out", out, 4'd0);
        check("midrst_s8_valid", {3'b000, valid}, 4'd1);

        // Idle cycles change nothing
        idle(); repeat (3) tick();
        check("idle_valid", {3'b000, valid}, 4'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            random_controls();
            rst = ($urandom_range(0, 19) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
